// File: rtl/ccff_chain_loader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : ccff_chain_loader
//  Description : Configuration-chain bitstream loader. Accepts parallel
//                configuration words over a valid/ready handshake and
//                serializes them MSB-first onto the chain head (ccff_head),
//                with a registered shift enable that gates the chain clock.
//                Issues exactly CHAIN_LEN shifts per load, accumulates the
//                XOR of bits returned on ccff_tail and flags completion.
//
//  Ports       : prog_clk      - programming clock (only clock)
//                pReset        - synchronous active-high reset
//                start         - load request pulse (honoured in IDLE/DONE)
//                word_data     - configuration word, MSB shifted first
//                word_valid    - word_data valid
//                word_ready    - word_data accepted this cycle
//                ccff_head     - serial bit to chain head (registered)
//                ccff_shift_en - chain shift enable (registered)
//                ccff_tail     - chain tail bit (old contents)
//                busy          - loading in progress
//                done          - load complete, held until start/reset
//                tail_parity   - XOR of tail samples in the current load
//                bit_count     - shifts issued in the current load
//
//  Revision    : 1.0 - initial release
// ============================================================================
module ccff_chain_loader #(
    parameter int CHAIN_LEN = 40,
    parameter int WORD_W    = 8,
    parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
    input  logic              prog_clk,
    input  logic              pReset,
    input  logic              start,
    input  logic [WORD_W-1:0] word_data,
    input  logic              word_valid,
    output logic              word_ready,
    output logic              ccff_head,
    output logic              ccff_shift_en,
    input  logic              ccff_tail,
    output logic              busy,
    output logic              done,
    output logic              tail_parity,
    output logic [CNT_W-1:0]  bit_count
);

    localparam int c_NWORDS = (CHAIN_LEN + WORD_W - 1) / WORD_W;
    localparam int c_BL_W   = $clog2(WORD_W + 1);
    localparam int c_WT_W   = $clog2(c_NWORDS + 1);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_LOAD = 2'd1;
    localparam logic [1:0] c_ST_DONE = 2'd2;

    localparam logic [CNT_W-1:0]  c_CNT_LAST = CNT_W'(CHAIN_LEN - 1);
    localparam logic [CNT_W-1:0]  c_CNT_FULL = CNT_W'(CHAIN_LEN);
    localparam logic [CNT_W-1:0]  c_CNT_ONE  = CNT_W'(1);
    localparam logic [c_BL_W-1:0] c_BL_ONE   = c_BL_W'(1);
    localparam logic [c_BL_W-1:0] c_BL_FULL  = c_BL_W'(WORD_W);
    localparam logic [c_WT_W-1:0] c_WT_ONE   = c_WT_W'(1);
    localparam logic [c_WT_W-1:0] c_WT_MAX   = c_WT_W'(c_NWORDS);

    logic [1:0]        r_state;
    logic [1:0]        w_next_state;
    logic [WORD_W-1:0] r_shreg;
    logic [c_BL_W-1:0] r_bits_left;
    logic [c_WT_W-1:0] r_words_taken;
    logic              r_head;
    logic              r_shift_en;
    logic              r_tail_parity;
    logic [CNT_W-1:0]  r_bit_count;

    logic w_busy;
    logic w_done;
    logic w_word_ready;
    logic w_start_load;
    logic w_shift;
    logic w_xfer;
    logic w_last_shift;

    assign w_start_load = start && ((r_state == c_ST_IDLE) || (r_state == c_ST_DONE));
    assign w_shift      = w_busy && (r_bits_left != '0) && (r_bit_count < c_CNT_FULL);
    assign w_xfer       = word_valid && w_word_ready;
    assign w_last_shift = w_shift && (r_bit_count == c_CNT_LAST);

    // State register
    always_ff @(posedge prog_clk) begin
        if (pReset) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_ST_IDLE: if (start)        w_next_state = c_ST_LOAD;
            c_ST_LOAD: if (w_last_shift) w_next_state = c_ST_DONE;
            c_ST_DONE: if (start)        w_next_state = c_ST_LOAD;
            default:                     w_next_state = c_ST_IDLE;
        endcase
    end

    // Output decode. Ready opens while the last bit of the current word is
    // being issued so the next word is prefetched without a bubble.
    always_comb begin
        w_busy       = (r_state == c_ST_LOAD);
        w_done       = (r_state == c_ST_DONE);
        w_word_ready = w_busy && (r_bits_left <= c_BL_ONE) && (r_words_taken < c_WT_MAX);
    end

    // Datapath
    always_ff @(posedge prog_clk) begin
        if (pReset) begin
            r_shreg       <= '0;
            r_bits_left   <= '0;
            r_words_taken <= '0;
            r_head        <= 1'b0;
            r_shift_en    <= 1'b0;
            r_tail_parity <= 1'b0;
            r_bit_count   <= '0;
        end else if (w_start_load) begin
            r_bits_left   <= '0;
            r_words_taken <= '0;
            r_shift_en    <= 1'b0;
            r_tail_parity <= 1'b0;
            r_bit_count   <= '0;
        end else begin
            r_shift_en <= w_shift;
            if (w_shift) begin
                r_head      <= r_shreg[WORD_W-1];
                r_shreg     <= {r_shreg[WORD_W-2:0], 1'b0};
                r_bits_left <= r_bits_left - c_BL_ONE;
                r_bit_count <= r_bit_count + c_CNT_ONE;
            end
            // A transfer coincides with a shift only when bits_left is 1:
            // the old MSB goes out and the new word replaces the register.
            if (w_xfer) begin
                r_shreg       <= word_data;
                r_bits_left   <= c_BL_FULL;
                r_words_taken <= r_words_taken + c_WT_ONE;
            end
            // Unshifted remainder of a partial final word is dropped.
            if (w_last_shift) begin
                r_bits_left <= '0;
            end
            // The chain shifts on edges where the registered enable is high,
            // so the tail bit present now is the one leaving the chain.
            if (r_shift_en) begin
                r_tail_parity <= r_tail_parity ^ ccff_tail;
            end
        end
    end

    assign word_ready    = w_word_ready;
    assign ccff_head     = r_head;
    assign ccff_shift_en = r_shift_en;
    assign busy          = w_busy;
    assign done          = w_done;
    assign tail_parity   = r_tail_parity;
    assign bit_count     = r_bit_count;

endmodule
`default_nettype wire

// File: tb/tb_ccff_chain_loader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_ccff_chain_loader
//  Description : Directed self-checking bench for ccff_chain_loader with a
//                40-bit/8-bit instance and a 20-bit/8-bit instance, each
//                driving a behavioural model of its configuration chain.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ccff_chain_loader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    // 40-bit chain instance
    logic       a_start, a_valid, a_ready, a_head, a_sen, a_tail, a_busy, a_done, a_par;
    logic [7:0] a_data;
    logic [5:0] a_cnt;

    // 20-bit chain instance
    logic       b_start, b_valid, b_ready, b_head, b_sen, b_tail, b_busy, b_done, b_par;
    logic [7:0] b_data;
    logic [4:0] b_cnt;

    ccff_chain_loader #(.CHAIN_LEN(40), .WORD_W(8)) u_dut_a (
        .prog_clk(clk), .pReset(rst), .start(a_start),
        .word_data(a_data), .word_valid(a_valid), .word_ready(a_ready),
        .ccff_head(a_head), .ccff_shift_en(a_sen), .ccff_tail(a_tail),
        .busy(a_busy), .done(a_done), .tail_parity(a_par), .bit_count(a_cnt)
    );

    ccff_chain_loader #(.CHAIN_LEN(20), .WORD_W(8)) u_dut_b (
        .prog_clk(clk), .pReset(rst), .start(b_start),
        .word_data(b_data), .word_valid(b_valid), .word_ready(b_ready),
        .ccff_head(b_head), .ccff_shift_en(b_sen), .ccff_tail(b_tail),
        .busy(b_busy), .done(b_done), .tail_parity(b_par), .bit_count(b_cnt)
    );

    // Chain models: index 0 is the head-side flop, top index the tail side.
    logic [39:0] a_chain = 40'h00000000F1;
    logic [19:0] b_chain = 20'h0;
    assign a_tail = a_chain[39];
    assign b_tail = b_chain[19];
    always @(posedge clk) if (a_sen) a_chain <= {a_chain[38:0], a_head};
    always @(posedge clk) if (b_sen) b_chain <= {b_chain[18:0], b_head};

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // One load on the 40-bit instance. Optional 3-cycle valid gap after the
    // second word, optional start pulse at bit_count 10, optional reset at
    // bit_count abort_at (0 = none).
    task automatic run_a(input logic [39:0] pat, input bit stall, input bit mid_start,
                         input int abort_at);
        logic        exp_par;
        logic [39:0] cap;
        int          wi, sh, gaps, badgap, stall_left, mid_phase;
        bit          seen_done, aborted, take;
        exp_par    = ^a_chain;
        cap        = '0;
        wi         = 0;
        sh         = 0;
        gaps       = 0;
        badgap     = 0;
        mid_phase  = 0;
        seen_done  = 0;
        aborted    = 0;
        stall_left = stall ? 3 : 0;

        a_start = 1'b1;
        tick;
        a_start = 1'b0;
        chk("a_busy_after_start", a_busy, 1);
        chk("a_cnt_cleared", a_cnt, 0);

        for (int cyc = 0; cyc < 200 && !seen_done && !aborted; cyc++) begin
            if (abort_at != 0 && a_cnt == abort_at[5:0]) begin
                rst = 1'b1;
                tick;
                rst = 1'b0;
                chk("rst_ready", a_ready, 0);
                chk("rst_head", a_head, 0);
                chk("rst_shift_en", a_sen, 0);
                chk("rst_busy", a_busy, 0);
                chk("rst_done", a_done, 0);
                chk("rst_parity", a_par, 0);
                chk("rst_cnt", a_cnt, 0);
                aborted = 1;
            end else begin
                if (wi < 5) begin
                    if (stall && wi == 2 && stall_left > 0 && a_ready) begin
                        a_valid = 1'b0;
                        stall_left--;
                    end else begin
                        a_valid = 1'b1;
                        a_data  = pat[39-8*wi -: 8];
                    end
                end else begin
                    a_valid = 1'b0;
                end
                take = a_valid && a_ready;
                if (mid_start && mid_phase == 0 && a_cnt == 6'd10) begin
                    a_start   = 1'b1;
                    mid_phase = 1;
                end
                tick;
                a_start = 1'b0;
                if (take) wi++;
                if (mid_phase == 1) begin
                    chk("a_mid_start_ignored", {a_busy, a_cnt}, {1'b1, 6'd11});
                    mid_phase = 2;
                end
                if (a_sen) begin
                    sh++;
                    cap = {cap[38:0], a_head};
                end else if (sh > 0 && !a_done) begin
                    gaps++;
                    if (a_cnt != 6'd16) badgap++;
                end
                if (a_done) begin
                    seen_done = 1;
                    chk("a_done_after_40th", sh, 40);
                    chk("a_done_last_en", a_sen, 1);
                end
            end
        end

        if (!aborted) begin
            chk("a_done_seen", seen_done, 1);
            chk("a_shift_count", sh, 40);
            chk("a_gap_cycles", gaps, stall ? 3 : 0);
            chk("a_gap_cnt_frozen", badgap, 0);
            chk("a_head_seq", cap, pat);
            chk("a_bit_count", a_cnt, 40);
            a_valid = 1'b1;
            chk("a_ready_in_done", a_ready, 0);
            tick;
            a_valid = 1'b0;
            chk("a_shift_en_done", a_sen, 0);
            chk("a_done_held", a_done, 1);
            chk("a_chain", a_chain, pat);
            chk("a_parity", a_par, exp_par);
        end
    endtask

    logic [7:0]  b_words [4] = '{8'hC3, 8'h5A, 8'hE7, 8'h99};
    logic [19:0] b_cap;
    int          b_wi, b_acc, b_sh;
    bit          b_seen, b_take;

    initial begin
        rst     = 1'b1;
        a_start = 1'b0; a_valid = 1'b0; a_data = 8'h00;
        b_start = 1'b0; b_valid = 1'b0; b_data = 8'h00;
        tick;
        tick;
        chk("reset_ready", a_ready, 0);
        chk("reset_head", a_head, 0);
        chk("reset_shift_en", a_sen, 0);
        chk("reset_busy", a_busy, 0);
        chk("reset_done", a_done, 0);
        chk("reset_parity", a_par, 0);
        chk("reset_cnt", a_cnt, 0);
        chk("reset_b_state", {b_busy, b_done, b_cnt}, 0);
        rst = 1'b0;

        // Valid offered in IDLE is never accepted and causes no shifts.
        a_valid = 1'b1;
        a_data  = 8'hFF;
        for (int i = 0; i < 3; i++) begin
            chk("idle_ready", a_ready, 0);
            tick;
            chk("idle_shift_en", a_sen, 0);
        end
        a_valid = 1'b0;

        // Chain preloaded with 0xF1: five ones come back.
        run_a(40'hA53CFF0081, 1'b0, 1'b0, 0);
        chk("parity_f1", a_par, 1);

        // Same pattern with a stall; chain ends identical.
        run_a(40'hA53CFF0081, 1'b1, 1'b0, 0);

        // All-zero load returns the previous pattern.
        run_a(40'h0000000000, 1'b0, 1'b0, 0);

        // Reset at bit_count 17, then a fresh full load with a stray start.
        run_a(40'h123456789A, 1'b0, 1'b0, 17);
        chk("post_abort_idle", {a_busy, a_done}, 0);
        tick;
        chk("post_abort_still_idle", {a_busy, a_sen}, 0);
        run_a(40'h123456789A, 1'b0, 1'b1, 0);

        // 20-bit chain: three words accepted, top nibble of the third used.
        b_cap  = '0;
        b_wi   = 0;
        b_acc  = 0;
        b_sh   = 0;
        b_seen = 0;
        b_start = 1'b1;
        tick;
        b_start = 1'b0;
        for (int cyc = 0; cyc < 100 && !b_seen; cyc++) begin
            b_valid = 1'b1;
            b_data  = b_words[b_wi];
            b_take  = b_ready;
            tick;
            if (b_take) begin
                b_acc++;
                if (b_wi < 3) b_wi++;
            end
            if (b_sen) begin
                b_sh++;
                b_cap = {b_cap[18:0], b_head};
            end
            if (b_done) b_seen = 1;
        end
        chk("b_done_seen", b_seen, 1);
        chk("b_bit_count", b_cnt, 20);
        for (int i = 0; i < 3; i++) begin
            if (b_ready) b_acc++;
            tick;
        end
        b_valid = 1'b0;
        chk("b_words_accepted", b_acc, 3);
        chk("b_shift_count", b_sh, 20);
        chk("b_head_seq", b_cap, 20'hC35AE);
        chk("b_chain", b_chain, 20'hC35AE);
        chk("b_idle_en", {b_sen, b_ready, b_done}, 3'b001);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
